// File: rtl/register_file_param.sv
// register_file_param: byte-enabled write port, two combinational read ports, optional
// hardwired-zero R0, optional write-to-read bypass and a per-register pending scoreboard.
module register_file_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [AW-1:0]        rd_addr_a,
    output logic [WIDTH-1:0]     rd_data_a,
    input  logic [AW-1:0]        rd_addr_b,
    output logic [WIDTH-1:0]     rd_data_b,
    input  logic                 lock_set,
    input  logic [AW-1:0]        lock_addr,
    output logic                 busy_a,
    output logic                 busy_b
);
    localparam int NB = WIDTH / 8;
    localparam int NA = 1 << AW;

    logic [NA-1:0]    addr_ok;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [DEPTH-1:0] wr_sel;
    logic [DEPTH-1:0] lock_sel;

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                               input logic [NB-1:0]    be,
                                               input logic [WIDTH-1:0] new_v);
        logic [WIDTH-1:0] res;
        res = old_v;
        for (int unsigned b = 0; b < NB; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Addresses that map to a real, writable register (out-of-range and zero R0 excluded)
    always_comb begin
        for (int unsigned i = 0; i < NA; i++) begin
            addr_ok[i] = (i < DEPTH) && !((ZERO_REG0 != 0) && (i == 0));
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
            wr_sel[r]   = wr_en && addr_ok[wr_addr] && (wr_addr == AW'(r));
            lock_sel[r] = lock_set && addr_ok[lock_addr] && (lock_addr == AW'(r));
            regs_d[r]   = wr_sel[r] ? merge(regs_q[r], wr_be, wr_data) : regs_q[r];
            // Set after clear so a same-cycle lock on the written register wins
            pend_d[r]   = lock_sel[r] | (pend_q[r] & ~wr_sel[r]);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned r = 0; r < DEPTH; r++) regs_q[r] <= '0;
            pend_q <= '0;
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) regs_q[r] <= regs_d[r];
            pend_q <= pend_d;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             bsy;

        assign addr = (p == 0) ? rd_addr_a : rd_addr_b;

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (addr == AW'(r)) begin
                    data = regs_q[r];
                    bsy  = pend_q[r];
                end
            end
            if (!addr_ok[addr]) begin
                data = '0;
                bsy  = 1'b0;
            end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
                data = merge(data, wr_be, wr_data);
                bsy  = lock_set && (lock_addr == addr);
            end
            if (clr) begin
                data = '0;
                bsy  = 1'b0;
            end
        end
    end

    assign rd_data_a = g_rd[0].data;
    assign rd_data_b = g_rd[1].data;
    assign busy_a    = g_rd[0].bsy;
    assign busy_b    = g_rd[1].bsy;

endmodule
